reg_pipe_n: RTL and testbench



---
 rtl/reg_pipe_pkg.sv | 15 +
 rtl/reg_stage.sv | 47 ++++
 rtl/reg_pipe_n.sv | 95 +++++++++
 tb/tb_reg_pipe_n.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_pipe_pkg.sv
// Shared constants and helpers for the reg_pipe_n register pipeline.
//   REG_PIPE_SIZE_DEF  : default data width in bits
//   REG_PIPE_DEPTH_DEF : default number of register stages
//   count_width()      : width of the occupancy counter, clog2(depth + 1)
package reg_pipe_pkg;

  localparam int unsigned REG_PIPE_SIZE_DEF  = 19;
  localparam int unsigned REG_PIPE_DEPTH_DEF = 4;

  // Enough bits to hold every value from 0 to depth inclusive.
  function automatic int unsigned count_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/reg_stage.sv
// One stage of the reg_pipe_n delay line: SIZE data bits plus a valid flag.
// Priority at each rising edge: rst (async) > clr > en > hold.
// Ports:
//   clk      system clock
//   rst      asynchronous active-high reset, clears data and valid
//   clr      synchronous flush, clears data and valid
//   en       advance enable, captures d / d_valid when high
//   d        data from the previous stage (or the pipe input)
//   d_valid  valid flag from the previous stage (or the pipe input)
//   q        registered data
//   q_valid  registered valid flag
module reg_stage
  import reg_pipe_pkg::*;
#(
  parameter int unsigned SIZE = REG_PIPE_SIZE_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            en,
  input  logic [SIZE-1:0] d,
  input  logic            d_valid,
  output logic [SIZE-1:0] q,
  output logic            q_valid
);

  logic [SIZE-1:0] data_q;
  logic            vld_q;

  // Data is captured even for bubbles; only the valid flag marks them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      vld_q  <= 1'b0;
    end else if (clr) begin
      data_q <= '0;
      vld_q  <= 1'b0;
    end else if (en) begin
      data_q <= d;
      vld_q  <= d_valid;
    end
  end

  assign q       = data_q;
  assign q_valid = vld_q;

endmodule

// File: rtl/reg_pipe_n.sv
// reg_pipe_n: DEPTH-stage, SIZE-bit register delay line with per-stage valid
// flags, a common advance enable and a synchronous flush.
// Configuration macro: REG_PIPE_COUNT_EN adds the Count port and the
// occupancy counter; without it there is no Count port and no counter.
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset
//   In         data captured into stage 0
//   In_valid   valid flag captured with In
//   EN         advance enable (shift when high, hold when low)
//   Clr        synchronous flush of every stage
//   Out        data of the last stage
//   Out_valid  valid flag of the last stage
//   Count      number of valid stages (REG_PIPE_COUNT_EN only)
module reg_pipe_n
  import reg_pipe_pkg::*;
#(
  parameter int unsigned SIZE  = REG_PIPE_SIZE_DEF,
  parameter int unsigned DEPTH = REG_PIPE_DEPTH_DEF
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [SIZE-1:0]                 In,
  input  logic                            In_valid,
  input  logic                            EN,
  input  logic                            Clr,
  output logic [SIZE-1:0]                 Out,
`ifdef REG_PIPE_COUNT_EN
  output logic                            Out_valid,
  output logic [count_width(DEPTH)-1:0]   Count
`else
  output logic                            Out_valid
`endif
);

  logic [SIZE-1:0] data [DEPTH];
  logic [DEPTH-1:0] vld;

  for (genvar i = 0; i < int'(DEPTH); i++) begin : g_stage
    logic [SIZE-1:0] d_in;
    logic            v_in;

    if (i == 0) begin : g_head
      assign d_in = In;
      assign v_in = In_valid;
    end else begin : g_link
      assign d_in = data[i-1];
      assign v_in = vld[i-1];
    end

    reg_stage #(
      .SIZE(SIZE)
    ) u_stage (
      .clk    (clk),
      .rst    (rst),
      .clr    (Clr),
      .en     (EN),
      .d      (d_in),
      .d_valid(v_in),
      .q      (data[i]),
      .q_valid(vld[i])
    );
  end

  assign Out       = data[DEPTH-1];
  assign Out_valid = vld[DEPTH-1];

`ifdef REG_PIPE_COUNT_EN
  localparam int unsigned CW = count_width(DEPTH);

  logic [CW-1:0] count_q, count_d;

  // Incoming valid adds one, the word leaving the last stage removes one;
  // the result is bounded by DEPTH because it mirrors the valid flags.
  always_comb begin
    count_d = count_q;
    if (EN) begin
      count_d = count_q + CW'(In_valid) - CW'(vld[DEPTH-1]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (Clr) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign Count = count_q;
`endif

endmodule

// File: tb/tb_reg_pipe_n.sv
// Self-checking bench for reg_pipe_n: a DEPTH=4 and a DEPTH=1 instance share
// the same stimulus and are compared against queue-based reference models.
module tb_reg_pipe_n;

  localparam int unsigned SIZE = 19;

  logic            clk;
  logic            rst;
  logic [SIZE-1:0] in_w;
  logic            in_valid;
  logic            en;
  logic            clr;
  logic [SIZE-1:0] out4, out1;
  logic            out_valid4, out_valid1;
`ifdef REG_PIPE_COUNT_EN
  logic [2:0]      count4;
  logic [0:0]      count1;
`endif

  reg_pipe_n #(
    .SIZE (SIZE),
    .DEPTH(4)
  ) dut4 (
    .clk      (clk),
    .rst      (rst),
    .In       (in_w),
    .In_valid (in_valid),
    .EN       (en),
    .Clr      (clr),
    .Out      (out4),
`ifdef REG_PIPE_COUNT_EN
    .Out_valid(out_valid4),
    .Count    (count4)
`else
    .Out_valid(out_valid4)
`endif
  );

  reg_pipe_n #(
    .SIZE (SIZE),
    .DEPTH(1)
  ) dut1 (
    .clk      (clk),
    .rst      (rst),
    .In       (in_w),
    .In_valid (in_valid),
    .EN       (en),
    .Clr      (clr),
    .Out      (out1),
`ifdef REG_PIPE_COUNT_EN
    .Out_valid(out_valid1),
    .Count    (count1)
`else
    .Out_valid(out_valid1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Reference models: index 0 is stage 0, the back of the queue is the output.
  logic [SIZE-1:0] m4_d[$];
  bit              m4_v[$];
  logic [SIZE-1:0] m1_d[$];
  bit              m1_v[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_clear();
    m4_d.delete(); m4_v.delete(); m1_d.delete(); m1_v.delete();
    repeat (4) begin m4_d.push_back('0); m4_v.push_back(1'b0); end
    m1_d.push_back('0); m1_v.push_back(1'b0);
  endtask

  task automatic model_edge(input logic c, input logic e, input logic [SIZE-1:0] d,
                            input logic v);
    if (c) begin
      model_clear();
    end else if (e) begin
      m4_d.push_front(d); m4_v.push_front(v); void'(m4_d.pop_back()); void'(m4_v.pop_back());
      m1_d.push_front(d); m1_v.push_front(v); void'(m1_d.pop_back()); void'(m1_v.pop_back());
    end
  endtask

  function automatic int model_count4();
    int n = 0;
    foreach (m4_v[i]) n += int'(m4_v[i]);
    return n;
  endfunction

  task automatic compare_model(input string tag);
    check({tag, " out4"}, 32'(out4), 32'(m4_d[3]));
    check({tag, " valid4"}, 32'(out_valid4), 32'(m4_v[3]));
    check({tag, " out1"}, 32'(out1), 32'(m1_d[0]));
    check({tag, " valid1"}, 32'(out_valid1), 32'(m1_v[0]));
`ifdef REG_PIPE_COUNT_EN
    check({tag, " count4"}, 32'(count4), 32'(model_count4()));
    check({tag, " count1"}, 32'(count1), 32'(m1_v[0]));
`endif
  endtask

  // Drive inputs away from the edge, clock once, then sample 1 unit later.
  task automatic step(input string tag, input logic c, input logic e,
                      input logic [SIZE-1:0] d, input logic v);
    clr = c; en = e; in_w = d; in_valid = v;
    @(posedge clk);
    model_edge(c, e, d, v);
    #1;
    compare_model(tag);
  endtask

  // Asynchronous reset pulse between edges; checked before any clock edge.
  task automatic async_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    model_clear();
    check({tag, " rst out4"}, 32'(out4), 32'h0);
    check({tag, " rst valid4"}, 32'(out_valid4), 32'h0);
    check({tag, " rst out1"}, 32'(out1), 32'h0);
`ifdef REG_PIPE_COUNT_EN
    check({tag, " rst count4"}, 32'(count4), 32'h0);
`endif
    #1 rst = 1'b0;
  endtask

  typedef struct {
    logic            en;
    logic [SIZE-1:0] d;
    logic            v;
    logic [SIZE-1:0] exp_out;
    logic            exp_valid;
    int              exp_count;
  } vec_t;

  vec_t lat_tab[7];
  logic [SIZE-1:0] frozen;
  int              max_cnt;

  initial begin
    rst = 1'b1; clr = 1'b0; en = 1'b0; in_w = '0; in_valid = 1'b0;
    model_clear();
    #12;
    check("por out4", 32'(out4), 32'h0);
    check("por valid4", 32'(out_valid4), 32'h0);
    rst = 1'b0;

    // Reset with the pipe full of all-ones words.
    for (int i = 0; i < 4; i++) step("fill", 1'b0, 1'b1, 19'h7FFFF, 1'b1);
    check("full out", 32'(out4), 32'h7FFFF);
    async_reset("full");

    // Latency table: 1,2,3 then bubbles, EN=1 throughout.
    lat_tab[0] = '{1'b1, 19'h00001, 1'b1, 19'h0,     1'b0, 1};
    lat_tab[1] = '{1'b1, 19'h00002, 1'b1, 19'h0,     1'b0, 2};
    lat_tab[2] = '{1'b1, 19'h00003, 1'b1, 19'h0,     1'b0, 3};
    lat_tab[3] = '{1'b1, 19'h00000, 1'b0, 19'h00001, 1'b1, 3};
    lat_tab[4] = '{1'b1, 19'h00000, 1'b0, 19'h00002, 1'b1, 2};
    lat_tab[5] = '{1'b1, 19'h00000, 1'b0, 19'h00003, 1'b1, 1};
    lat_tab[6] = '{1'b1, 19'h00000, 1'b0, 19'h00000, 1'b0, 0};
    for (int i = 0; i < 7; i++) begin
      step("lat", 1'b0, lat_tab[i].en, lat_tab[i].d, lat_tab[i].v);
      check($sformatf("lat%0d out", i), 32'(out4), 32'(lat_tab[i].exp_out));
      check($sformatf("lat%0d valid", i), 32'(out_valid4), 32'(lat_tab[i].exp_valid));
`ifdef REG_PIPE_COUNT_EN
      check($sformatf("lat%0d count", i), 32'(count4), 32'(lat_tab[i].exp_count));
`endif
    end

    // Stall: 12345 then a bubble, 3 stalled edges, then 2 more enabled edges.
    step("stall pre", 1'b1, 1'b0, '0, 1'b0);
    step("stall e1", 1'b0, 1'b1, 19'h12345, 1'b1);
    step("stall e2", 1'b0, 1'b1, 19'h0, 1'b0);
    frozen = out4;
    for (int i = 0; i < 3; i++) begin
      step("stall hold", 1'b0, 1'b0, 19'h7ABCD, 1'b1);
      check("stall frozen out", 32'(out4), 32'(frozen));
      check("stall frozen valid", 32'(out_valid4), 32'h0);
`ifdef REG_PIPE_COUNT_EN
      check("stall frozen count", 32'(count4), 32'h1);
`endif
    end
    step("stall e6", 1'b0, 1'b1, 19'h0, 1'b0);
    check("stall not yet", 32'(out_valid4), 32'h0);
    step("stall e7", 1'b0, 1'b1, 19'h0, 1'b0);
    check("stall out", 32'(out4), 32'h12345);
    check("stall valid", 32'(out_valid4), 32'h1);

    // Flush with Clr and EN together; the flushed-in word must never appear.
    for (int i = 0; i < 4; i++) step("flush fill", 1'b0, 1'b1, 19'(32'h100 + i), 1'b1);
    step("flush", 1'b1, 1'b1, 19'h0ABCD, 1'b1);
    check("flush out", 32'(out4), 32'h0);
    check("flush valid", 32'(out_valid4), 32'h0);
`ifdef REG_PIPE_COUNT_EN
    check("flush count", 32'(count4), 32'h0);
`endif
    for (int i = 0; i < 5; i++) begin
      step("flush drain", 1'b0, 1'b1, 19'h0, 1'b0);
      check("flush never", 32'(out4 == 19'h0ABCD), 32'h0);
    end

    // Bubble mix 1,0,1,0.
    max_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step("mix", 1'b0, 1'b1, 19'(32'h200 + i), (i < 4) ? ((i % 2) == 0) : 1'b0);
      if (i >= 3 && i <= 6)
        check($sformatf("mix valid%0d", i + 1), 32'(out_valid4), 32'((i % 2) == 1));
`ifdef REG_PIPE_COUNT_EN
      if (int'(count4) > max_cnt) max_cnt = int'(count4);
`else
      if (model_count4() > max_cnt) max_cnt = model_count4();
`endif
    end
    check("mix max count", 32'(max_cnt <= 2), 32'h1);

    // DEPTH=1 instance: capture, hold, clear.
    step("d1 cap", 1'b0, 1'b1, 19'h55555, 1'b1);
    check("d1 out", 32'(out1), 32'h55555);
    check("d1 valid", 32'(out_valid1), 32'h1);
    step("d1 hold", 1'b0, 1'b0, 19'h2AAAA, 1'b0);
    check("d1 hold out", 32'(out1), 32'h55555);
    step("d1 clr", 1'b1, 1'b0, 19'h2AAAA, 1'b1);
    check("d1 clr out", 32'(out1), 32'h0);
    check("d1 clr valid", 32'(out_valid1), 32'h0);

    // Randomised traffic with occasional flush and asynchronous reset.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 63) == 0) async_reset("rnd");
      step("rnd", ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
           19'($urandom), 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
